fetch_queue_unit: RTL and testbench

Instruction fetch stage that sits directly upstream of the byte-addressed instruction memory and directly downstream of the decode stage's redirect logic.
- Owns the program counter and drives iaddr/cs_n into the combinational-read instruction memory.
- Captures the returned instruction word together with its PC into a small in-order queue.
- Presents queue entries to decode over a valid/ready handshake.
- Absorbs decode stalls without refetching, and flushes on branch/jump redirect.

---
 rtl/fetch_queue_unit.sv | 137 +++++++++++++
 tb/tb_fetch_queue_unit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue_unit.sv
// Fetch stage: owns the PC, reads instruction memory and buffers {pc, instr} in an in-order queue for decode.
// Optional FETCH_PERF_CNT_EN adds fetch and decode-stall counters.
module fetch_queue_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] iaddr,
  output logic        cs_n,
  input  logic [31:0] instrCode,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        id_ready,
  output logic        misalign_err
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(QDEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [31:0]   NOP      = 32'h0000_0013;

  typedef enum logic [1:0] {BOOT, FETCH, FULL} state_e;

  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic          misalign_q, misalign_d;
  logic          push, pop, full;

  logic [31:0] instrMem_q [QDEPTH];
  logic [31:0] pcMem_q    [QDEPTH];

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    count_d    = count_q;
    head_d     = head_q;
    tail_d     = tail_q;
    misalign_d = 1'b0;
    full       = (count_q == FULL_CNT);
    pop        = (count_q != '0) && id_ready;
    push       = (state_q == FETCH) && !redirect_valid && (!full || pop);

    // Redirect flushes everything and overrides push, pop and the FULL wait.
    if (redirect_valid) begin
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
      pc_d       = {redirect_pc[31:2], 2'b00};
      state_d    = FETCH;
      misalign_d = (redirect_pc[1:0] != 2'b00);
    end else begin
      if (push) begin
        tail_d = tail_q + PTR_ONE;
        pc_d   = pc_q + 32'd4;
      end
      if (pop) begin
        head_d = head_q + PTR_ONE;
      end
      if (push && !pop) begin
        count_d = count_q + CNT_ONE;
      end else if (pop && !push) begin
        count_d = count_q - CNT_ONE;
      end
      case (state_q)
        BOOT:    state_d = FETCH;
        FETCH:   if (full && !pop) state_d = FULL;
        FULL:    if (pop) state_d = FETCH;
        default: state_d = BOOT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      misalign_q <= misalign_d;
    end
  end

  // Queue storage needs no reset: count gates visibility of every entry.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      instrMem_q[tail_q] <= instrCode;
      pcMem_q[tail_q]    <= pc_q;
    end
  end

  assign iaddr        = pc_q;
  assign cs_n         = (state_q != FETCH);
  assign if_valid     = (count_q != '0);
  assign if_instr     = if_valid ? instrMem_q[head_q] : NOP;
  assign if_pc        = if_valid ? pcMem_q[head_q] : 32'h0000_0000;
  assign misalign_err = misalign_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetchCnt_q, stallCnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetchCnt_q <= '0;
      stallCnt_q <= '0;
    end else begin
      if (push) fetchCnt_q <= fetchCnt_q + 32'd1;
      if (if_valid && !id_ready) stallCnt_q <= stallCnt_q + 32'd1;
    end
  end

  assign perf_fetch_cnt = fetchCnt_q;
  assign perf_stall_cnt = stallCnt_q;
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit: reset, fetch, stall/full, redirect, misalign, PC wrap, mid-run reset.
module tb_fetch_queue_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        idReady;
  logic        redirectValid;
  logic [31:0] redirectPc;
  logic [31:0] iaddr, instrCode, ifInstr, ifPc;
  logic        csN, ifValid, misalignErr;

  logic [31:0] iaddr2, instrCode2, ifInstr2, ifPc2;
  logic        csN2, ifValid2, misalignErr2;

  int checkCount = 0;
  int passCount  = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] addr);
    case (addr)
      32'h0000_0000: memWord = 32'h0050_0093;
      32'h0000_0004: memWord = 32'h0010_0113;
      default:       memWord = addr ^ 32'h5A5A_0003;
    endcase
  endfunction

  assign instrCode  = memWord(iaddr);
  assign instrCode2 = memWord(iaddr2);

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perfFetch, perfStall, perfFetch2, perfStall2;
`endif

  fetch_queue_unit dut (
    .clk(clk), .rst(rst), .iaddr(iaddr), .cs_n(csN), .instrCode(instrCode),
    .redirect_valid(redirectValid), .redirect_pc(redirectPc),
    .if_valid(ifValid), .if_instr(ifInstr), .if_pc(ifPc),
    .id_ready(idReady), .misalign_err(misalignErr)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetch_cnt(perfFetch), .perf_stall_cnt(perfStall)
`endif
  );

  fetch_queue_unit #(.RESET_PC(32'hFFFF_FFFC)) dutWrap (
    .clk(clk), .rst(rst), .iaddr(iaddr2), .cs_n(csN2), .instrCode(instrCode2),
    .redirect_valid(1'b0), .redirect_pc(32'h0000_0000),
    .if_valid(ifValid2), .if_instr(ifInstr2), .if_pc(ifPc2),
    .id_ready(1'b1), .misalign_err(misalignErr2)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetch_cnt(perfFetch2), .perf_stall_cnt(perfStall2)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 time unit into the single BOOT cycle.
  task automatic applyReset(input logic ready);
    rst = 1'b1; idReady = ready; redirectValid = 1'b0; redirectPc = 32'h0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idReady = 1'b1; redirectValid = 1'b0; redirectPc = 32'h0;
    tick(); tick(); tick();
    checkCount++; if (csN !== 1'b1) $display("[TB] FAIL reset_cs_n: got %b want 1", csN); else passCount++;
    checkCount++; if (ifValid !== 1'b0) $display("[TB] FAIL reset_if_valid: got %b want 0", ifValid); else passCount++;
    checkCount++; if (ifInstr !== NOP) $display("[TB] FAIL reset_if_instr: got %h want %h", ifInstr, NOP); else passCount++;
    checkCount++; if (ifPc !== 32'h0) $display("[TB] FAIL reset_if_pc: got %h want 0", ifPc); else passCount++;
    checkCount++; if (iaddr !== 32'h0) $display("[TB] FAIL reset_iaddr: got %h want 0", iaddr); else passCount++;
    checkCount++; if (misalignErr !== 1'b0) $display("[TB] FAIL reset_misalign: got %b want 0", misalignErr); else passCount++;
  endtask

  task automatic test_basic_fetch();
    rst = 1'b0;
    checkCount++; if (csN !== 1'b1) $display("[TB] FAIL boot_cs_n: got %b want 1", csN); else passCount++;
    tick();
    checkCount++; if (csN !== 1'b0) $display("[TB] FAIL fetch_cs_n: got %b want 0", csN); else passCount++;
    checkCount++; if (iaddr !== 32'h0) $display("[TB] FAIL fetch_iaddr: got %h want 0", iaddr); else passCount++;
    checkCount++; if (ifValid !== 1'b0) $display("[TB] FAIL fetch_early_valid: got %b want 0", ifValid); else passCount++;
    tick();
    checkCount++; if (ifValid !== 1'b1) $display("[TB] FAIL first_valid: got %b want 1", ifValid); else passCount++;
    checkCount++; if (ifInstr !== 32'h0050_0093) $display("[TB] FAIL first_instr: got %h want 00500093", ifInstr); else passCount++;
    checkCount++; if (ifPc !== 32'h0) $display("[TB] FAIL first_pc: got %h want 0", ifPc); else passCount++;
    tick();
    checkCount++; if (ifPc !== 32'h4) $display("[TB] FAIL second_pc: got %h want 4", ifPc); else passCount++;
    checkCount++; if (ifInstr !== 32'h0010_0113) $display("[TB] FAIL second_instr: got %h want 00100113", ifInstr); else passCount++;
  endtask

  task automatic test_full_stall();
    logic [31:0] expPc;
    applyReset(1'b0);
    for (int i = 0; i < 6; i++) tick();
    checkCount++; if (csN !== 1'b1) $display("[TB] FAIL full_cs_n: got %b want 1", csN); else passCount++;
    checkCount++; if (iaddr !== 32'h10) $display("[TB] FAIL full_iaddr: got %h want 10", iaddr); else passCount++;
    tick();
    checkCount++; if (iaddr !== 32'h10) $display("[TB] FAIL full_iaddr_hold: got %h want 10", iaddr); else passCount++;
    checkCount++; if (ifPc !== 32'h0) $display("[TB] FAIL full_head_pc: got %h want 0", ifPc); else passCount++;
    idReady = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      expPc = 32'(4 + 4 * i);
      checkCount++; if (ifValid !== 1'b1 || ifPc !== expPc) $display("[TB] FAIL drain_pc: got %b/%h want 1/%h", ifValid, ifPc, expPc); else passCount++;
      checkCount++; if (ifInstr !== memWord(expPc)) $display("[TB] FAIL drain_instr: got %h want %h", ifInstr, memWord(expPc)); else passCount++;
      if (i == 0) begin
        checkCount++; if (csN !== 1'b0) $display("[TB] FAIL refetch_cs_n: got %b want 0", csN); else passCount++;
      end
    end
  endtask

  task automatic test_redirect();
    applyReset(1'b0);
    for (int i = 0; i < 4; i++) tick();
    redirectValid = 1'b1; redirectPc = 32'h100;
    tick();
    redirectValid = 1'b0; idReady = 1'b1;
    checkCount++; if (ifValid !== 1'b0) $display("[TB] FAIL redir_flush_valid: got %b want 0", ifValid); else passCount++;
    checkCount++; if (iaddr !== 32'h100) $display("[TB] FAIL redir_iaddr: got %h want 100", iaddr); else passCount++;
    checkCount++; if (misalignErr !== 1'b0) $display("[TB] FAIL redir_aligned_err: got %b want 0", misalignErr); else passCount++;
    tick();
    checkCount++; if (ifValid !== 1'b1 || ifPc !== 32'h100) $display("[TB] FAIL redir_target: got %b/%h want 1/100", ifValid, ifPc); else passCount++;
    checkCount++; if (ifInstr !== memWord(32'h100)) $display("[TB] FAIL redir_instr: got %h want %h", ifInstr, memWord(32'h100)); else passCount++;
    tick();
    checkCount++; if (ifPc !== 32'h104) $display("[TB] FAIL redir_next_pc: got %h want 104", ifPc); else passCount++;
  endtask

  task automatic test_misalign();
    redirectValid = 1'b1; redirectPc = 32'h102;
    tick();
    redirectValid = 1'b0;
    checkCount++; if (misalignErr !== 1'b1) $display("[TB] FAIL misalign_pulse: got %b want 1", misalignErr); else passCount++;
    checkCount++; if (iaddr !== 32'h100) $display("[TB] FAIL misalign_iaddr: got %h want 100", iaddr); else passCount++;
    tick();
    checkCount++; if (misalignErr !== 1'b0) $display("[TB] FAIL misalign_one_cycle: got %b want 0", misalignErr); else passCount++;
    checkCount++; if (ifValid !== 1'b1 || ifPc !== 32'h100) $display("[TB] FAIL misalign_target: got %b/%h want 1/100", ifValid, ifPc); else passCount++;
    redirectValid = 1'b1; redirectPc = 32'h203;
    tick();
    checkCount++; if (misalignErr !== 1'b1 || iaddr !== 32'h200) $display("[TB] FAIL b2b_first: got %b/%h want 1/200", misalignErr, iaddr); else passCount++;
    redirectPc = 32'h300;
    tick();
    redirectValid = 1'b0;
    checkCount++; if (misalignErr !== 1'b0 || iaddr !== 32'h300 || ifValid !== 1'b0) $display("[TB] FAIL b2b_second: got %b/%h/%b want 0/300/0", misalignErr, iaddr, ifValid); else passCount++;
    tick();
    checkCount++; if (ifValid !== 1'b1 || ifPc !== 32'h300) $display("[TB] FAIL b2b_last_wins: got %b/%h want 1/300", ifValid, ifPc); else passCount++;
  endtask

  task automatic test_boot_redirect();
    applyReset(1'b1);
    redirectValid = 1'b1; redirectPc = 32'h40;
    checkCount++; if (csN !== 1'b1) $display("[TB] FAIL bootredir_cs_n: got %b want 1", csN); else passCount++;
    tick();
    redirectValid = 1'b0;
    checkCount++; if (csN !== 1'b0 || iaddr !== 32'h40 || ifValid !== 1'b0) $display("[TB] FAIL bootredir_fetch: got %b/%h/%b want 0/40/0", csN, iaddr, ifValid); else passCount++;
    tick();
    checkCount++; if (ifValid !== 1'b1 || ifPc !== 32'h40) $display("[TB] FAIL bootredir_target: got %b/%h want 1/40", ifValid, ifPc); else passCount++;
  endtask

  task automatic test_pc_wrap();
    applyReset(1'b1);
    tick();
    checkCount++; if (csN2 !== 1'b0 || iaddr2 !== 32'hFFFF_FFFC) $display("[TB] FAIL wrap_iaddr: got %b/%h want 0/fffffffc", csN2, iaddr2); else passCount++;
    tick();
    checkCount++; if (ifValid2 !== 1'b1 || ifPc2 !== 32'hFFFF_FFFC) $display("[TB] FAIL wrap_first_pc: got %b/%h want 1/fffffffc", ifValid2, ifPc2); else passCount++;
    tick();
    checkCount++; if (ifPc2 !== 32'h0) $display("[TB] FAIL wrap_to_zero: got %h want 0", ifPc2); else passCount++;
    checkCount++; if (ifInstr2 !== 32'h0050_0093) $display("[TB] FAIL wrap_instr: got %h want 00500093", ifInstr2); else passCount++;
  endtask

  task automatic test_reset_mid_op();
    applyReset(1'b0);
    for (int i = 0; i < 7; i++) tick();
    checkCount++; if (csN !== 1'b1 || ifValid !== 1'b1) $display("[TB] FAIL midrst_full: got %b/%b want 1/1", csN, ifValid); else passCount++;
    rst = 1'b1; redirectValid = 1'b1; redirectPc = 32'h103;
    tick();
    rst = 1'b0; redirectValid = 1'b0;
    checkCount++; if (ifValid !== 1'b0 || csN !== 1'b1 || iaddr !== 32'h0) $display("[TB] FAIL midrst_clear: got %b/%b/%h want 0/1/0", ifValid, csN, iaddr); else passCount++;
    checkCount++; if (misalignErr !== 1'b0 || ifInstr !== NOP) $display("[TB] FAIL midrst_outputs: got %b/%h want 0/%h", misalignErr, ifInstr, NOP); else passCount++;
    tick();
    checkCount++; if (csN !== 1'b0 || iaddr !== 32'h0) $display("[TB] FAIL midrst_resume: got %b/%h want 0/0", csN, iaddr); else passCount++;
    tick();
    checkCount++; if (ifValid !== 1'b1 || ifPc !== 32'h0) $display("[TB] FAIL midrst_first: got %b/%h want 1/0", ifValid, ifPc); else passCount++;
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_full_stall();
    test_redirect();
    test_misalign();
    test_boot_redirect();
    test_pc_wrap();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
